// File: rtl/interrupt_dispatcher_pkg.sv
// rtl/interrupt_dispatcher_pkg.sv - shared types and constants for the interrupt dispatcher
package interrupt_dispatcher_pkg;

    // Five interrupt sources; bit position is also the priority (0 = highest)
    localparam int INT_WIDTH = 5;
    localparam int IDX_WIDTH = 3;

    localparam int INT_VBLANK  = 0;
    localparam int INT_LCDSTAT = 1;
    localparam int INT_TIMER   = 2;
    localparam int INT_SERIAL  = 3;
    localparam int INT_JOYPAD  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_PUSH_HI = 3'd2,
        ST_PUSH_LO = 3'd3,
        ST_JUMP    = 3'd4
    } intd_state_t;

    // One-hot IF clear mask for a serviced source index
    function automatic logic [7:0] idx_to_mask(input logic [IDX_WIDTH-1:0] idx);
        logic [7:0] one;
        one = 8'h01;
        return one << idx;
    endfunction

endpackage

// File: rtl/intd_priority_enc.sv
// rtl/intd_priority_enc.sv - lowest-set-bit priority encoder for the five interrupt sources
import interrupt_dispatcher_pkg::*;

module intd_priority_enc (
    input  logic [INT_WIDTH-1:0] req,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 valid
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = INT_WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_dispatcher.sv
// rtl/interrupt_dispatcher.sv - interrupt dispatch sequencer (optional INTD_HALT_WAKE_EN)
import interrupt_dispatcher_pkg::*;

module interrupt_dispatcher #(
    parameter logic [15:0] VECTOR_BASE   = 16'h0040,
    parameter int          VECTOR_STRIDE = 8
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [7:0]  iPending,
    input  logic        iBoundary,
    input  logic        iEi,
    input  logic        iDi,
    input  logic        iReti,
    input  logic [15:0] iPc,
    input  logic        iStackAck,
    output logic        oIme,
    output logic        oBusy,
    output logic        oPushReq,
    output logic [7:0]  oPushData,
    output logic        oLoadPc,
    output logic [15:0] oVector,
    output logic        oIfClearWe,
    output logic [7:0]  oIfClearMask,
    output logic        oHaltWake
);

    intd_state_t          state;
    logic                 ei_pend;
    logic [1:0]           wait_cnt;
    logic [IDX_WIDTH-1:0] idx_q;
    logic [15:0]          pc_q;

    logic [IDX_WIDTH-1:0] enc_idx;
    logic                 enc_valid;
    logic                 dispatch_go;
    logic [15:0]          vec_calc;

    // Bits 7:5 of the pending word carry no interrupt sources
    logic unused_pending_hi;
    assign unused_pending_hi = ^iPending[7:5];

    intd_priority_enc u_enc (
        .req   (iPending[INT_WIDTH-1:0]),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign dispatch_go = iBoundary && oIme && enc_valid;
    assign vec_calc    = VECTOR_BASE + ({13'd0, idx_q} * 16'(VECTOR_STRIDE));
    assign oBusy       = (state != ST_IDLE);

`ifdef INTD_HALT_WAKE_EN
    assign oHaltWake = |iPending[INT_WIDTH-1:0];
`else
    assign oHaltWake = 1'b0;
`endif

    // Dispatch sequencer, IME/EI bookkeeping and registered strobe outputs
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state        <= ST_IDLE;
            oIme         <= 1'b0;
            ei_pend      <= 1'b0;
            wait_cnt     <= 2'd0;
            idx_q        <= '0;
            pc_q         <= 16'h0000;
            oPushReq     <= 1'b0;
            oPushData    <= 8'h00;
            oLoadPc      <= 1'b0;
            oVector      <= 16'h0000;
            oIfClearWe   <= 1'b0;
            oIfClearMask <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dispatch_go) begin
                        // Priority is frozen here; later arrivals cannot redirect the vector
                        state    <= ST_WAIT;
                        idx_q    <= enc_idx;
                        pc_q     <= iPc;
                        wait_cnt <= 2'd0;
                    end
                    if (iDi) begin
                        oIme    <= 1'b0;
                        ei_pend <= 1'b0;
                    end else if (dispatch_go) begin
                        oIme <= 1'b0;
                    end else if (iBoundary && ei_pend) begin
                        // EI takes effect one instruction late, so this boundary never dispatches
                        oIme    <= 1'b1;
                        ei_pend <= 1'b0;
                    end else begin
                        if (iReti) begin
                            oIme <= 1'b1;
                        end
                        if (iEi) begin
                            ei_pend <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 2'd1) begin
                        state     <= ST_PUSH_HI;
                        wait_cnt  <= 2'd0;
                        oPushReq  <= 1'b1;
                        oPushData <= pc_q[15:8];
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                ST_PUSH_HI: begin
                    if (iStackAck) begin
                        state     <= ST_PUSH_LO;
                        oPushData <= pc_q[7:0];
                    end
                end
                ST_PUSH_LO: begin
                    if (iStackAck) begin
                        state        <= ST_JUMP;
                        oPushReq     <= 1'b0;
                        oPushData    <= 8'h00;
                        oLoadPc      <= 1'b1;
                        oVector      <= vec_calc;
                        oIfClearWe   <= 1'b1;
                        oIfClearMask <= idx_to_mask(idx_q);
                    end
                end
                ST_JUMP: begin
                    state        <= ST_IDLE;
                    oLoadPc      <= 1'b0;
                    oVector      <= 16'h0000;
                    oIfClearWe   <= 1'b0;
                    oIfClearMask <= 8'h00;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// tb/tb_interrupt_dispatcher.sv - scoreboard bench for interrupt_dispatcher
module tb_interrupt_dispatcher;

    logic        iClock = 1'b0;
    logic        iReset;
    logic [7:0]  iPending;
    logic        iBoundary;
    logic        iEi;
    logic        iDi;
    logic        iReti;
    logic [15:0] iPc;
    logic        iStackAck;
    logic        oIme;
    logic        oBusy;
    logic        oPushReq;
    logic [7:0]  oPushData;
    logic        oLoadPc;
    logic [15:0] oVector;
    logic        oIfClearWe;
    logic [7:0]  oIfClearMask;
    logic        oHaltWake;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        bit          is_jump;
        logic [7:0]  data;
        logic [15:0] vec;
        logic [7:0]  mask;
    } exp_t;

    exp_t expq[$];

    always #5 iClock = ~iClock;

    interrupt_dispatcher dut (
        .iClock       (iClock),
        .iReset       (iReset),
        .iPending     (iPending),
        .iBoundary    (iBoundary),
        .iEi          (iEi),
        .iDi          (iDi),
        .iReti        (iReti),
        .iPc          (iPc),
        .iStackAck    (iStackAck),
        .oIme         (oIme),
        .oBusy        (oBusy),
        .oPushReq     (oPushReq),
        .oPushData    (oPushData),
        .oLoadPc      (oLoadPc),
        .oVector      (oVector),
        .oIfClearWe   (oIfClearWe),
        .oIfClearMask (oIfClearMask),
        .oHaltWake    (oHaltWake)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s", name);
    endtask

    task automatic cyc();
        @(posedge iClock);
        #1;
    endtask

    task automatic push_exp(input bit j, input logic [7:0] d, input logic [15:0] v, input logic [7:0] m);
        exp_t e;
        e.is_jump = j;
        e.data    = d;
        e.vec     = v;
        e.mask    = m;
        expq.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int exp_cycles);
        int n;
        n = 0;
        while (oBusy && n < 50) begin
            cyc();
            n++;
        end
        if (oBusy) fail_now({name, "_timeout"});
        else if (exp_cycles > 0) check({name, "_latency"}, 16'(n), 16'(exp_cycles));
    endtask

    task automatic set_ime();
        iReti = 1'b1;
        cyc();
        iReti = 1'b0;
        check("reti_sets_ime", oIme, 1'b1);
    endtask

    // Monitor: pop and compare whenever the DUT presents a push handshake or a PC load
    initial begin
        exp_t e;
        forever begin
            @(negedge iClock);
            if (!iReset) begin
                if (oPushReq && iStackAck) begin
                    if (expq.size() == 0) begin
                        fail_now("unexpected_push");
                    end else begin
                        e = expq.pop_front();
                        check("push_kind", e.is_jump, 1'b0);
                        check("push_data", oPushData, e.data);
                    end
                end
                if (oLoadPc) begin
                    if (expq.size() == 0) begin
                        fail_now("unexpected_loadpc");
                    end else begin
                        e = expq.pop_front();
                        check("jump_kind", e.is_jump, 1'b1);
                        check("jump_vector", oVector, e.vec);
                        check("jump_mask", oIfClearMask, e.mask);
                    end
                end
                if (!oPushReq) check("pushdata_idle_zero", oPushData, 8'h00);
                if (!oLoadPc) check("vector_idle_zero", oVector, 16'h0000);
                if (!oIfClearWe) check("mask_idle_zero", oIfClearMask, 8'h00);
                check("clearwe_with_loadpc", oIfClearWe, oLoadPc);
            end
        end
    end

    initial begin
        logic exp_wake;
        iReset    = 1'b1;
        iPending  = 8'h00;
        iBoundary = 1'b0;
        iEi       = 1'b0;
        iDi       = 1'b0;
        iReti     = 1'b0;
        iPc       = 16'h0000;
        iStackAck = 1'b1;
        cyc();
        cyc();
        check("rst_ime", oIme, 1'b0);
        check("rst_busy", oBusy, 1'b0);
        check("rst_pushreq", oPushReq, 1'b0);
        check("rst_pushdata", oPushData, 8'h00);
        check("rst_loadpc", oLoadPc, 1'b0);
        check("rst_vector", oVector, 16'h0000);
        check("rst_clearwe", oIfClearWe, 1'b0);
        check("rst_mask", oIfClearMask, 8'h00);
        iReset = 1'b0;
        cyc();

        // Timer dispatch, five cycles with ack tied high
        set_ime();
        push_exp(0, 8'h12, 16'h0, 8'h0);
        push_exp(0, 8'h34, 16'h0, 8'h0);
        push_exp(1, 8'h00, 16'h0050, 8'h04);
        iPending  = 8'h04;
        iPc       = 16'h1234;
        iBoundary = 1'b1;
        cyc();
        iBoundary = 1'b0;
        check("timer_ime_cleared", oIme, 1'b0);
        check("timer_busy", oBusy, 1'b1);
        wait_idle("timer", 5);
        check("timer_queue_empty", 16'(expq.size()), 16'd0);
        iPending = 8'h00;
        cyc();

        // Priority fixed at entry despite VBLANK arriving during WAIT
        set_ime();
        push_exp(0, 8'h02, 16'h0, 8'h0);
        push_exp(0, 8'h00, 16'h0, 8'h0);
        push_exp(1, 8'h00, 16'h0048, 8'h02);
        iPending  = 8'h1A;
        iPc       = 16'h0200;
        iBoundary = 1'b1;
        cyc();
        iBoundary = 1'b0;
        iPending  = 8'h1B;
        wait_idle("prio", 5);
        check("prio_queue_empty", 16'(expq.size()), 16'd0);
        check("prio_ime_after", oIme, 1'b0);
        iPending = 8'h00;
        cyc();

        // EI delay: enabling boundary does not dispatch
        iEi = 1'b1;
        cyc();
        iEi = 1'b0;
        check("ei_not_immediate", oIme, 1'b0);
        iPending  = 8'h01;
        iBoundary = 1'b1;
        cyc();
        iBoundary = 1'b0;
        check("ei_boundary_ime", oIme, 1'b1);
        check("ei_boundary_no_dispatch", oBusy, 1'b0);
        cyc();
        check("ei_still_idle", oBusy, 1'b0);
        push_exp(0, 8'hAB, 16'h0, 8'h0);
        push_exp(0, 8'hCD, 16'h0, 8'h0);
        push_exp(1, 8'h00, 16'h0040, 8'h01);
        iPc       = 16'hABCD;
        iBoundary = 1'b1;
        cyc();
        iBoundary = 1'b0;
        iPending  = 8'h00;
        check("ei_next_dispatch", oBusy, 1'b1);
        wait_idle("ei", 5);
        check("ei_queue_empty", 16'(expq.size()), 16'd0);

        // DI wins over simultaneous EI; RETI re-enables on the next edge
        set_ime();
        iEi = 1'b1;
        iDi = 1'b1;
        cyc();
        iEi = 1'b0;
        iDi = 1'b0;
        check("di_wins_ime", oIme, 1'b0);
        iPending  = 8'h01;
        iBoundary = 1'b1;
        cyc();
        iBoundary = 1'b0;
        check("di_cleared_ei_pend", oIme, 1'b0);
        check("di_no_dispatch", oBusy, 1'b0);
        iPending = 8'h00;
        iReti    = 1'b1;
        cyc();
        iReti = 1'b0;
        check("reti_after_di", oIme, 1'b1);

        // Stack backpressure in PUSH_HI, then reset in PUSH_LO
        push_exp(0, 8'h12, 16'h0, 8'h0);
        iStackAck = 1'b0;
        iPending  = 8'h04;
        iPc       = 16'h1234;
        iBoundary = 1'b1;
        cyc();
        iBoundary = 1'b0;
        cyc();
        cyc();
        iReti = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_pushreq", oPushReq, 1'b1);
            check("bp_pushdata", oPushData, 8'h12);
            cyc();
            iReti = 1'b0;
        end
        check("bp_reti_ignored_busy", oIme, 1'b0);
        iStackAck = 1'b1;
        cyc();
        iStackAck = 1'b0;
        check("bp_lo_pushreq", oPushReq, 1'b1);
        check("bp_lo_pushdata", oPushData, 8'h34);
        iReset = 1'b1;
        cyc();
        iReset = 1'b0;
        check("rst_mid_busy", oBusy, 1'b0);
        check("rst_mid_loadpc", oLoadPc, 1'b0);
        check("rst_mid_clearwe", oIfClearWe, 1'b0);
        check("rst_mid_pushreq", oPushReq, 1'b0);
        check("rst_mid_ime", oIme, 1'b0);
        check("bp_queue_empty", 16'(expq.size()), 16'd0);
        iStackAck = 1'b1;
        cyc();
        check("rst_mid_stays_idle", oBusy, 1'b0);

        // HALT wake with IME clear
`ifdef INTD_HALT_WAKE_EN
        exp_wake = 1'b1;
`else
        exp_wake = 1'b0;
`endif
        iPending  = 8'h10;
        iBoundary = 1'b1;
        #1;
        check("halt_wake", oHaltWake, exp_wake);
        cyc();
        iBoundary = 1'b0;
        check("halt_no_dispatch", oBusy, 1'b0);
        iPending = 8'h00;
        #1;
        check("halt_wake_clear", oHaltWake, 1'b0);
        cyc();
        cyc();
        check("final_queue_empty", 16'(expq.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/interrupt_dispatcher.md
INTERRUPT_DISPATCHER -- requirements
Module: interrupt_dispatcher

Interface
REQ-001 Parameter VECTOR_BASE, default 16'h0040, SHALL set the vector address of pending bit 0.
REQ-002 Parameter VECTOR_STRIDE, default 8, SHALL set the address step between consecutive bit vectors.
REQ-003 iClock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 iReset  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 iPending  input  8  SHALL carry raw IF & IE; bits 7:5 are ignored.
REQ-006 iBoundary  input  1  SHALL pulse when the CPU sits at an instruction boundary, before the opcode fetch.
REQ-007 iEi / iDi / iReti  input  1 each  SHALL be one-cycle decode pulses for EI, DI and RETI.
REQ-008 iPc  input  16  SHALL be the CPU program counter, sampled at dispatch entry.
REQ-009 iStackAck  input  1  SHALL indicate the stack write accepted the current oPushData byte.
REQ-010 oIme  output  1  SHALL be the interrupt master enable.
REQ-011 oBusy  output  1  SHALL be high in every state except IDLE; the CPU stalls fetch while it is high.
REQ-012 oPushReq / oPushData  output  1 / 8  SHALL carry the stack push request and the byte to push.
REQ-013 oLoadPc / oVector  output  1 / 16  SHALL be a one-cycle PC load strobe and the target address.
REQ-014 oIfClearWe / oIfClearMask  output  1 / 8  SHALL be a one-cycle strobe and one-hot mask that clear the serviced IF bit.
REQ-015 oHaltWake  output  1  SHALL be the HALT exit request.

Function
REQ-016 States SHALL be IDLE, WAIT, PUSH_HI, PUSH_LO and JUMP.
REQ-017 IDLE->WAIT SHALL occur when iBoundary, oIme and |iPending[4:0] are all high in the same cycle.
REQ-018 On IDLE->WAIT the block SHALL latch the lowest set bit of iPending[4:0] as idx, latch iPc, and clear oIme.
REQ-019 WAIT SHALL last exactly 2 cycles (2-bit counter), then go to PUSH_HI.
REQ-020 PUSH_HI SHALL drive oPushReq=1 and oPushData=PC[15:8], holding until iStackAck, then go to PUSH_LO.
REQ-021 PUSH_LO SHALL drive oPushReq=1 and oPushData=PC[7:0], holding until iStackAck, then go to JUMP.
REQ-022 JUMP SHALL last 1 cycle with oLoadPc=1, oVector=VECTOR_BASE+idx*VECTOR_STRIDE, oIfClearWe=1 and oIfClearMask=1<<idx, then go to IDLE.
REQ-023 Minimum dispatch latency SHALL be 5 cycles, entry edge to JUMP exit, when iStackAck is tied high.
REQ-024 Priority is fixed at entry: a higher-priority bit arriving after entry SHALL NOT change idx.
REQ-025 iEi SHALL set ei_pend; at the next iBoundary oIme becomes 1 and ei_pend clears.
REQ-026 That enabling boundary SHALL NOT start a dispatch; the earliest dispatch is at the following boundary.
REQ-027 iReti SHALL set oIme on the next edge, with no delay.
REQ-028 iDi SHALL clear oIme and ei_pend on the next edge.
REQ-029 iDi SHALL win over a simultaneous iEi or iReti.
REQ-030 iEi, iReti and iDi SHALL be ignored while oBusy=1.
REQ-031 Strobe outputs (oPushReq, oLoadPc, oIfClearWe) SHALL be zero outside their states.
REQ-032 oPushData, oVector and oIfClearMask SHALL be zero whenever their strobe is low.
REQ-033 If iPending clears during WAIT, the dispatch SHALL still complete to the latched vector.

Reset
REQ-034 iReset SHALL force IDLE, oIme=0, ei_pend=0 and the WAIT counter to 0.
REQ-035 iReset SHALL drive all outputs to 0, including oVector=16'h0000.
REQ-036 Reset mid-dispatch SHALL abandon the sequence with no oLoadPc and no oIfClearWe, and be IDLE the next cycle.

Configuration
REQ-037 With INTD_HALT_WAKE_EN defined, oHaltWake SHALL equal |iPending[4:0], combinational and independent of oIme and state.
REQ-038 Without INTD_HALT_WAKE_EN, oHaltWake SHALL be tied 0 and no wake logic SHALL be synthesized.

Structure
REQ-039 A shared package SHALL hold the state enum, the 5-bit interrupt mask width, and the VBLANK/LCDSTAT/TIMER/SERIAL/JOYPAD bit indices.
REQ-040 One sub-module, intd_priority_enc (5-bit lowest-set-bit to 3-bit index plus valid), SHALL be instantiated; all other logic stays flat.

Verification
REQ-041 Timer dispatch: oIme=1, iPending=8'h04, iPc=16'h1234, iBoundary, iStackAck=1.
  -> Push 8'h12 then 8'h34; JUMP with oVector=16'h0050 and oIfClearMask=8'h04; oIme=0; 5 cycles total.
REQ-042 Priority: iPending=8'h1A at entry.
  -> oVector=16'h0048 and mask 8'h02; raising bit 0 during WAIT does not change them.
REQ-043 EI delay: iEi, then iBoundary with iPending=8'h01.
  -> No dispatch; oIme=1 afterwards; the next iBoundary dispatches to 16'h0040.
REQ-044 Simultaneous iEi and iDi with oIme=1 -> oIme=0 and ei_pend=0; iReti afterwards -> oIme=1 the next cycle.
REQ-045 Stack backpressure: iStackAck low for 3 cycles in PUSH_HI.
  -> oPushData held at 8'h12; iReset asserted in PUSH_LO -> IDLE with no oLoadPc.
REQ-046 HALT wake: with INTD_HALT_WAKE_EN, oIme=0 and iPending=8'h10 -> oHaltWake=1 and no dispatch; without the macro, oHaltWake=0.
